// File: rtl/entropy_uart_tx.sv
// -----------------------------------------------------------------------------
// entropy_uart_tx
//
// Takes one 32-bit entropy word at a time from the entropy core's valid/ack
// handshake and sends it on the UART TX pin as four 8N1 bytes, most
// significant byte first. Each byte goes out LSB first.
//
// Parameters:
//   CLK_DIV       clock cycles per UART bit (2..65535), default 104
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   enable        allows new words to be accepted; a word already in flight
//                 always completes
//   entropy_data  entropy word, valid while entropy_valid=1
//   entropy_valid core has a word available
//   entropy_ack   one-cycle pulse when the word on entropy_data is consumed
//   txd           UART serial out, idles high
//   busy          a word is being transmitted
//   word_count    number of words fully transmitted since reset (wraps)
// -----------------------------------------------------------------------------
module entropy_uart_tx #(
  parameter int CLK_DIV = 104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] entropy_data,
  input  logic        entropy_valid,
  output logic        entropy_ack,
  output logic        txd,
  output logic        busy,
  output logic [31:0] word_count
);

  // The bit timer counts 0..CLK_DIV-1, so it needs ceil(log2(CLK_DIV)) bits,
  // and at least one bit.
  localparam int            TW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   word_q, word_d;
  logic          txd_q, txd_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic [31:0]   count_q, count_d;

  logic          bit_done;
  logic [7:0]    cur_byte;

  assign bit_done = (timer_q == TMAX);
  // Byte index 0 selects bits [31:24]. ~byte_idx_q equals 3 - byte_idx_q,
  // which gives most-significant-byte-first order.
  assign cur_byte = word_q[{~byte_idx_q, 3'b000} +: 8];

  always_comb begin
    // NOTE: every signal gets a default before the case. This avoids latches,
    // and blocking '=' is correct inside combinational logic.
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    txd_d      = txd_q;
    ack_d      = 1'b0;
    busy_d     = busy_q;
    count_d    = count_q;

    // The timer restarts at every bit boundary, so bit lengths never drift.
    if (state_q != IDLE) begin
      timer_d = bit_done ? '0 : timer_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (enable && entropy_valid) begin
          word_d     = entropy_data;
          byte_idx_d = 2'd0;
          bit_idx_d  = 3'd0;
          state_d    = START;
          txd_d      = 1'b0;
          ack_d      = 1'b1;
          busy_d     = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          txd_d     = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = cur_byte[bit_idx_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          if (byte_idx_q != 2'd3) begin
            // The next start bit follows the stop bit with no idle gap.
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = START;
            txd_d      = 1'b0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            count_d = count_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking '<=' only.
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      txd_q      <= 1'b1;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      txd_q      <= txd_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      count_q    <= count_d;
    end
  end

  // NOTE: the shift word has no reset. It is read only after a capture has
  // loaded it, and a reset simply discards it.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign entropy_ack = ack_q;
  assign txd         = txd_q;
  assign busy        = busy_q;
  assign word_count  = count_q;

endmodule

// File: doc/entropy_uart_tx.md
Name: entropy_uart_tx

Overview:
Consumer end of the entropy core's valid/ack output handshake. Accepts one 32-bit entropy word at a time from the ring-oscillator entropy core and serializes it as four 8N1 UART bytes on the iCEstick FTDI TX pin, so a host can collect raw random data. Sits in the top level between the entropy core outputs and the board UART pin.

Parameters:
CLK_DIV, 104, clock cycles per UART bit (12 MHz / 104 ≈ 115200 baud); legal range 2..65535.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  permits acceptance of new words; does not abort a word in flight
entropy_data  input  32  entropy word from the core; valid while entropy_valid=1
entropy_valid  input  1  core has a word available
entropy_ack  output  1  one-cycle pulse; the word on entropy_data is consumed
txd  output  1  UART serial out, idle high
busy  output  1  a word is being transmitted
word_count  output  32  number of words fully transmitted since reset

Behaviour:
- Reset (reset=1 at a rising edge): next cycle txd=1, entropy_ack=0, busy=0, word_count=0, FSM=IDLE, all counters cleared. This applies mid-frame: the frame is truncated, and the captured word is discarded without being re-requested.
- All outputs are registered.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: txd=1, busy=0. At an edge with enable=1 and entropy_valid=1:
  - capture entropy_data into the shift word;
  - set byte index=0 and go to START.
  - In the following cycle entropy_ack=1, busy=1, and txd=0 (start bit), all beginning on the same edge.
- entropy_ack is high for exactly one cycle per accepted word and never while entropy_valid was low at the capture edge.
- START: txd=0 for CLK_DIV cycles, then DATA.
- DATA: 8 bits, LSB first, each held CLK_DIV cycles, then STOP.
- STOP: txd=1 for CLK_DIV cycles. Then:
  - if byte index<3: increment the index and go to START, with no gap between the stop bit and the next start bit;
  - else: go to IDLE, word_count += 1 (wraps 0xFFFFFFFF→0) and busy=0, all on that same edge.
- Byte order: most significant byte first (data[31:24], [23:16], [15:8], [7:0]).
- Word frame length: 40*CLK_DIV cycles. IDLE always lasts at least one cycle, so back-to-back words with entropy_valid held high start every 40*CLK_DIV+1 cycles.
- entropy_valid while busy is ignored: no ack, no capture. The core holds the word until the next IDLE acceptance.
- enable=0 in IDLE: no acceptance. enable falling mid-word: the current word completes normally, then the FSM stays in IDLE.
- Bit timer: counts 0..CLK_DIV-1. It has width ceil(log2(CLK_DIV)), minimum 1 bit, and reloads on every bit boundary with no drift.
- Simultaneous reset and entropy_valid: reset wins; no ack is issued.

Test Plan:
1. Reset values, CLK_DIV=4: hold reset 3 cycles, release with valid=0 → txd=1, busy=0, entropy_ack=0, word_count=0 for 50 cycles.
2. Single word, CLK_DIV=4, enable=1, data=0xA5C30F81, valid pulsed until ack:
   - ack is high exactly 1 cycle, coincident with txd falling;
   - the decoded bytes are A5, C3, 0F, 81, each framed 0/LSB-first/1 with 4-cycle bits;
   - busy is high for 160 cycles, then word_count=1.
3. Back-to-back, CLK_DIV=4, valid held high with data 0x00000000 then 0xFFFFFFFF → start-bit falling edges 161 cycles apart, two ack pulses, word_count=2; the second word is all 0xFF bytes.
4. enable gating:
   - enable=0 with valid=1 for 500 cycles → no ack, txd=1;
   - then enable=1 and deassert enable 10 cycles later → the word completes (160 cycles), word_count=1, and there is no second ack while enable=0.
5. Reset mid-frame, CLK_DIV=4: assert reset during byte 2's data bits → next cycle txd=1, busy=0, word_count=0. After release with valid=1, a new ack occurs and a full frame follows.
6. Large divider, CLK_DIV=104: send 0x5A5A5A5A → each bit lasts exactly 104 cycles, total busy 4160 cycles, and a UART monitor at 115200 baud from a 12 MHz clock decodes 5A ×4.
